// File: rtl/exe_fwd_unit_pkg.sv
// Shared encodings for the execute-stage datapath slice.
package exe_fwd_unit_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  typedef enum logic [2:0] {
    CMP_NONE = 3'd0,
    CMP_EQ   = 3'd1,
    CMP_NE   = 3'd2,
    CMP_LT   = 3'd3,
    CMP_GE   = 3'd4,
    CMP_LTU  = 3'd5,
    CMP_GEU  = 3'd6
  } cmp_op_e;

endpackage

// File: rtl/exe_fwd_unit_fwd_sel.sv
// Hazard match for one source operand: picks M, then W, then the register file.
module exe_fwd_unit_fwd_sel #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned SEL_WIDTH = 4
) (
  input  logic [SEL_WIDTH-1:0] reg_select,
  input  logic [WIDTH-1:0]     reg_value,
  input  logic                 is_write_m,
  input  logic [SEL_WIDTH-1:0] dest_m,
  input  logic [WIDTH-1:0]     data_m,
  input  logic                 is_write_w,
  input  logic [SEL_WIDTH-1:0] dest_w,
  input  logic [WIDTH-1:0]     data_w,
  output logic                 forward_c,
  output logic                 select_c,
  output logic [WIDTH-1:0]     operand_c
);

  // M is the younger producer, so it has priority over W; index 0 is not special.
  always_comb begin
    forward_c = 1'b0;
    select_c  = 1'b0;
    operand_c = reg_value;
    if (is_write_m && (dest_m == reg_select)) begin
      forward_c = 1'b1;
      operand_c = data_m;
    end else if (is_write_w && (dest_w == reg_select)) begin
      forward_c = 1'b1;
      select_c  = 1'b1;
      operand_c = data_w;
    end
  end

endmodule

// File: rtl/exe_fwd_unit.sv
// Execute-stage slice: operand forwarding, ALU, branch comparator, A->M registers.
module exe_fwd_unit
  import exe_fwd_unit_pkg::*;
#(
  parameter int unsigned REG_WIDTH  = 32,
  parameter int unsigned REG_SELECT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_enable,
  input  logic [REG_SELECT-1:0] i_reg_a_select,
  input  logic [REG_SELECT-1:0] i_reg_b_select,
  input  logic [REG_WIDTH-1:0]  i_reg_a,
  input  logic [REG_WIDTH-1:0]  i_reg_b,
  input  logic                  i_is_write_M,
  input  logic [REG_SELECT-1:0] i_reg_c_select_M,
  input  logic [REG_WIDTH-1:0]  i_data_M,
  input  logic                  i_is_write_W,
  input  logic [REG_SELECT-1:0] i_reg_c_select_W,
  input  logic [REG_WIDTH-1:0]  i_data_W,
  input  logic                  i_use_offset,
  input  logic [REG_WIDTH-1:0]  i_offset,
  input  alu_op_e               i_alu_op,
  input  cmp_op_e               i_cmp_op,
  output logic                  o_forward_a,
  output logic                  o_forward_b,
  output logic                  o_select_forward_a,
  output logic                  o_select_forward_b,
  output logic [REG_WIDTH-1:0]  o_a,
  output logic [REG_WIDTH-1:0]  o_b_fwd,
  output logic [REG_WIDTH-1:0]  o_alu_data,
  output logic                  o_cmp,
  output logic [REG_WIDTH-1:0]  o_alu_data_q,
  output logic [REG_WIDTH-1:0]  o_reg_b_q
);

  localparam int unsigned SHAMT_W = $clog2(REG_WIDTH);

  logic [REG_WIDTH-1:0] alu_b;
  logic [SHAMT_W-1:0]   shamt;

  exe_fwd_unit_fwd_sel #(
    .WIDTH    (REG_WIDTH),
    .SEL_WIDTH(REG_SELECT)
  ) u_fwd_a (
    .reg_select(i_reg_a_select),
    .reg_value (i_reg_a),
    .is_write_m(i_is_write_M),
    .dest_m    (i_reg_c_select_M),
    .data_m    (i_data_M),
    .is_write_w(i_is_write_W),
    .dest_w    (i_reg_c_select_W),
    .data_w    (i_data_W),
    .forward_c (o_forward_a),
    .select_c  (o_select_forward_a),
    .operand_c (o_a)
  );

  exe_fwd_unit_fwd_sel #(
    .WIDTH    (REG_WIDTH),
    .SEL_WIDTH(REG_SELECT)
  ) u_fwd_b (
    .reg_select(i_reg_b_select),
    .reg_value (i_reg_b),
    .is_write_m(i_is_write_M),
    .dest_m    (i_reg_c_select_M),
    .data_m    (i_data_M),
    .is_write_w(i_is_write_W),
    .dest_w    (i_reg_c_select_W),
    .data_w    (i_data_W),
    .forward_c (o_forward_b),
    .select_c  (o_select_forward_b),
    .operand_c (o_b_fwd)
  );

  // Loads/stores add the immediate; the forwarded B still travels as store data.
  assign alu_b = i_use_offset ? i_offset : o_b_fwd;
  assign shamt = alu_b[SHAMT_W-1:0];

  // ALU: wraps modulo 2^REG_WIDTH, unknown opcodes give zero.
  always_comb begin
    o_alu_data = '0;
    case (i_alu_op)
      ALU_ADD:  o_alu_data = o_a + alu_b;
      ALU_SUB:  o_alu_data = o_a - alu_b;
      ALU_AND:  o_alu_data = o_a & alu_b;
      ALU_OR:   o_alu_data = o_a | alu_b;
      ALU_XOR:  o_alu_data = o_a ^ alu_b;
      ALU_SLL:  o_alu_data = o_a << shamt;
      ALU_SRL:  o_alu_data = o_a >> shamt;
      ALU_SRA:  o_alu_data = REG_WIDTH'($signed(o_a) >>> shamt);
      ALU_SLT:  o_alu_data = REG_WIDTH'($signed(o_a) < $signed(alu_b));
      ALU_SLTU: o_alu_data = REG_WIDTH'(o_a < alu_b);
      default:  o_alu_data = '0;
    endcase
  end

  // Branch comparator on forwarded operands; NONE keeps the PC from redirecting.
  always_comb begin
    o_cmp = 1'b0;
    case (i_cmp_op)
      CMP_NONE: o_cmp = 1'b0;
      CMP_EQ:   o_cmp = (o_a == o_b_fwd);
      CMP_NE:   o_cmp = (o_a != o_b_fwd);
      CMP_LT:   o_cmp = ($signed(o_a) < $signed(o_b_fwd));
      CMP_GE:   o_cmp = ($signed(o_a) >= $signed(o_b_fwd));
      CMP_LTU:  o_cmp = (o_a < o_b_fwd);
      CMP_GEU:  o_cmp = (o_a >= o_b_fwd);
      default:  o_cmp = 1'b0;
    endcase
  end

  // A->M pipeline boundary: ALU result and store data, stalled by i_enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_alu_data_q <= '0;
      o_reg_b_q    <= '0;
    end else if (i_enable) begin
      o_alu_data_q <= o_alu_data;
      o_reg_b_q    <= o_b_fwd;
    end
  end

endmodule

// File: tb/tb_exe_fwd_unit.sv
// Self-checking bench for exe_fwd_unit: directed scenarios plus randomized model checks.
module tb_exe_fwd_unit;
  import exe_fwd_unit_pkg::*;

  localparam int unsigned W = 32;
  localparam int unsigned S = 4;

  logic          clk;
  logic          rst;
  logic          i_enable;
  logic [S-1:0]  i_reg_a_select, i_reg_b_select;
  logic [W-1:0]  i_reg_a, i_reg_b;
  logic          i_is_write_M, i_is_write_W;
  logic [S-1:0]  i_reg_c_select_M, i_reg_c_select_W;
  logic [W-1:0]  i_data_M, i_data_W;
  logic          i_use_offset;
  logic [W-1:0]  i_offset;
  alu_op_e       i_alu_op;
  cmp_op_e       i_cmp_op;
  logic          o_forward_a, o_forward_b, o_select_forward_a, o_select_forward_b;
  logic [W-1:0]  o_a, o_b_fwd, o_alu_data, o_alu_data_q, o_reg_b_q;
  logic          o_cmp;

  int ncmp = 0;
  int nfail = 0;

  exe_fwd_unit #(.REG_WIDTH(W), .REG_SELECT(S)) dut (
    .clk(clk), .rst(rst), .i_enable(i_enable),
    .i_reg_a_select(i_reg_a_select), .i_reg_b_select(i_reg_b_select),
    .i_reg_a(i_reg_a), .i_reg_b(i_reg_b),
    .i_is_write_M(i_is_write_M), .i_reg_c_select_M(i_reg_c_select_M), .i_data_M(i_data_M),
    .i_is_write_W(i_is_write_W), .i_reg_c_select_W(i_reg_c_select_W), .i_data_W(i_data_W),
    .i_use_offset(i_use_offset), .i_offset(i_offset),
    .i_alu_op(i_alu_op), .i_cmp_op(i_cmp_op),
    .o_forward_a(o_forward_a), .o_forward_b(o_forward_b),
    .o_select_forward_a(o_select_forward_a), .o_select_forward_b(o_select_forward_b),
    .o_a(o_a), .o_b_fwd(o_b_fwd), .o_alu_data(o_alu_data), .o_cmp(o_cmp),
    .o_alu_data_q(o_alu_data_q), .o_reg_b_q(o_reg_b_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  // Youngest writer matching the index supplies the value: M, then W, then the file.
  function automatic void model_operand(input logic [S-1:0] sel, input logic [W-1:0] rf,
                                        output logic fwd, output logic fsel,
                                        output logic [W-1:0] val);
    fwd = 1'b0; fsel = 1'b0; val = rf;
    if (i_is_write_M && i_reg_c_select_M == sel) begin
      fwd = 1'b1; val = i_data_M;
    end else if (i_is_write_W && i_reg_c_select_W == sel) begin
      fwd = 1'b1; fsel = 1'b1; val = i_data_W;
    end
  endfunction

  function automatic logic [W-1:0] model_alu(input int op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    int sh;
    longint sa, sb;
    logic [W-1:0] r;
    sh = int'(b % W);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      0: r = W'(a + b);
      1: r = W'(a - b);
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = W'(a * (64'd1 << sh));
      6: r = W'(a / (64'd1 << sh));
      7: r = a[W-1] ? ~((~a) >> sh) : (a >> sh);
      8: r = (sa < sb) ? 32'd1 : 32'd0;
      9: r = (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic model_cmp(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, ua, ub;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'(a); ub = longint'(b);
    case (op)
      1: return sa == sb;
      2: return sa != sb;
      3: return sa < sb;
      4: return sa >= sb;
      5: return ua < ub;
      6: return ua >= ub;
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive_idle();
    i_enable = 1'b1;
    i_reg_a_select = '0; i_reg_b_select = '0;
    i_reg_a = '0; i_reg_b = '0;
    i_is_write_M = 1'b0; i_reg_c_select_M = '0; i_data_M = '0;
    i_is_write_W = 1'b0; i_reg_c_select_W = '0; i_data_W = '0;
    i_use_offset = 1'b0; i_offset = '0;
    i_alu_op = ALU_ADD; i_cmp_op = CMP_NONE;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive_idle();
    rst = 1'b0;
    #1;
    ncmp++;
    if (o_alu_data_q !== 32'd0) begin nfail++; $display("FAIL reset_alu_q: got %h want 0", o_alu_data_q); end
    ncmp++;
    if (o_reg_b_q !== 32'd0) begin nfail++; $display("FAIL reset_b_q: got %h want 0", o_reg_b_q); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_no_hazard();
    @(negedge clk);
    drive_idle();
    i_reg_a_select = 4'd1; i_reg_b_select = 4'd2; i_reg_a = 32'd7; i_reg_b = 32'd5;
    #1;
    ncmp++;
    if ({o_forward_a, o_forward_b} !== 2'b00) begin nfail++; $display("FAIL nohaz_fwd: got %b want 00", {o_forward_a, o_forward_b}); end
    ncmp++;
    if (o_alu_data !== 32'd12) begin nfail++; $display("FAIL nohaz_alu: got %0d want 12", o_alu_data); end
    @(posedge clk); #1;
    ncmp++;
    if (o_alu_data_q !== 32'd12) begin nfail++; $display("FAIL nohaz_alu_q: got %0d want 12", o_alu_data_q); end
  endtask

  task automatic test_m_forward();
    @(negedge clk);
    drive_idle();
    i_is_write_M = 1'b1; i_reg_c_select_M = 4'd1; i_data_M = 32'd3;
    i_reg_a_select = 4'd1; i_reg_a = 32'd99; i_reg_b_select = 4'd2; i_reg_b = 32'd2;
    #1;
    ncmp++;
    if ({o_forward_a, o_select_forward_a} !== 2'b10) begin nfail++; $display("FAIL mfwd_flags: got %b want 10", {o_forward_a, o_select_forward_a}); end
    ncmp++;
    if (o_a !== 32'd3) begin nfail++; $display("FAIL mfwd_a: got %0d want 3", o_a); end
    ncmp++;
    if (o_alu_data !== 32'd5) begin nfail++; $display("FAIL mfwd_alu: got %0d want 5", o_alu_data); end
  endtask

  task automatic test_priority();
    @(negedge clk);
    drive_idle();
    i_is_write_M = 1'b1; i_reg_c_select_M = 4'd2; i_data_M = 32'd10;
    i_is_write_W = 1'b1; i_reg_c_select_W = 4'd2; i_data_W = 32'd20;
    i_reg_b_select = 4'd2; i_reg_b = 32'd77;
    #1;
    ncmp++;
    if (o_b_fwd !== 32'd10 || o_select_forward_b !== 1'b0) begin
      nfail++; $display("FAIL prio_m: got %0d/%b want 10/0", o_b_fwd, o_select_forward_b);
    end
    i_is_write_M = 1'b0;
    #1;
    ncmp++;
    if (o_b_fwd !== 32'd20 || o_select_forward_b !== 1'b1) begin
      nfail++; $display("FAIL prio_w: got %0d/%b want 20/1", o_b_fwd, o_select_forward_b);
    end
    // Register 0 forwards like any other index.
    i_reg_c_select_W = 4'd0; i_reg_a_select = 4'd0; i_reg_a = 32'd1;
    #1;
    ncmp++;
    if (o_a !== 32'd20 || o_forward_a !== 1'b1) begin
      nfail++; $display("FAIL prio_r0: got %0d/%b want 20/1", o_a, o_forward_a);
    end
  endtask

  task automatic test_offset();
    @(negedge clk);
    drive_idle();
    i_reg_a_select = 4'd3; i_reg_a = 32'd1; i_reg_b_select = 4'd4; i_reg_b = 32'd9;
    i_use_offset = 1'b1; i_offset = 32'd4;
    #1;
    ncmp++;
    if (o_alu_data !== 32'd5) begin nfail++; $display("FAIL offs_alu: got %0d want 5", o_alu_data); end
    @(posedge clk); #1;
    ncmp++;
    if (o_reg_b_q !== 32'd9) begin nfail++; $display("FAIL offs_store_q: got %0d want 9", o_reg_b_q); end
    ncmp++;
    if (o_alu_data_q !== 32'd5) begin nfail++; $display("FAIL offs_alu_q: got %0d want 5", o_alu_data_q); end
  endtask

  task automatic test_compare();
    logic [4:0] got;
    @(negedge clk);
    drive_idle();
    i_reg_a_select = 4'd1; i_reg_b_select = 4'd2; i_reg_a = 32'd2; i_reg_b = 32'd2;
    i_cmp_op = CMP_EQ;   #1; got[0] = o_cmp;
    i_cmp_op = CMP_NE;   #1; got[1] = o_cmp;
    i_cmp_op = CMP_NONE; #1; got[2] = o_cmp;
    i_reg_a = 32'hFFFF_FFFF; i_reg_b = 32'd1;
    i_cmp_op = CMP_LT;   #1; got[3] = o_cmp;
    i_cmp_op = CMP_LTU;  #1; got[4] = o_cmp;
    ncmp++;
    if (got !== 5'b01001) begin nfail++; $display("FAIL cmp_dir {ltu,lt,none,ne,eq}: got %b want 01001", got); end
    i_cmp_op = cmp_op_e'(3'd7); #1;
    ncmp++;
    if (o_cmp !== 1'b0) begin nfail++; $display("FAIL cmp_unknown: got %b want 0", o_cmp); end
  endtask

  task automatic test_reset_hold();
    @(negedge clk);
    drive_idle();
    i_reg_a = 32'd2; i_reg_b = 32'd3; i_reg_a_select = 4'd1; i_reg_b_select = 4'd2;
    @(posedge clk); #1;
    ncmp++;
    if (o_alu_data_q !== 32'd5) begin nfail++; $display("FAIL hold_load: got %0d want 5", o_alu_data_q); end
    #2 rst = 1'b0;
    #1;
    ncmp++;
    if (o_alu_data_q !== 32'd0 || o_reg_b_q !== 32'd0) begin
      nfail++; $display("FAIL async_reset: got %0d/%0d want 0/0", o_alu_data_q, o_reg_b_q);
    end
    @(negedge clk);
    rst = 1'b1; i_enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_reg_a = $urandom; i_reg_b = $urandom;
      @(posedge clk); #1;
      ncmp++;
      if (o_alu_data_q !== 32'd0 || o_reg_b_q !== 32'd0) begin
        nfail++; $display("FAIL hold_edge%0d: got %0d/%0d want 0/0", k, o_alu_data_q, o_reg_b_q);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] exp_alu_q, exp_b_q, ea, eb, ealu;
    logic efa, efb, esa, esb, ecmp;
    int errs;
    errs = 0;
    @(negedge clk);
    drive_idle();
    rst = 1'b0; #1; rst = 1'b1;
    exp_alu_q = '0; exp_b_q = '0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      i_enable = ($urandom_range(0, 3) != 0);
      i_reg_a_select = S'($urandom_range(0, 3));
      i_reg_b_select = S'($urandom_range(0, 3));
      i_reg_a = $urandom; i_reg_b = ($urandom_range(0, 3) == 0) ? i_reg_a : $urandom;
      i_is_write_M = 1'($urandom); i_reg_c_select_M = S'($urandom_range(0, 3)); i_data_M = $urandom;
      i_is_write_W = 1'($urandom); i_reg_c_select_W = S'($urandom_range(0, 3)); i_data_W = $urandom;
      i_use_offset = 1'($urandom); i_offset = (n % 2 == 0) ? W'($urandom_range(0, 40)) : $urandom;
      i_alu_op = alu_op_e'(4'($urandom_range(0, 11)));
      i_cmp_op = cmp_op_e'(3'($urandom_range(0, 7)));
      #1;
      model_operand(i_reg_a_select, i_reg_a, efa, esa, ea);
      model_operand(i_reg_b_select, i_reg_b, efb, esb, eb);
      ealu = model_alu(int'(i_alu_op), ea, i_use_offset ? i_offset : eb);
      ecmp = model_cmp(int'(i_cmp_op), ea, eb);
      ncmp++;
      if ({o_forward_a, o_select_forward_a, o_forward_b, o_select_forward_b} !== {efa, esa, efb, esb}
          || o_a !== ea || o_b_fwd !== eb) begin
        nfail++; errs++;
        if (errs < 10) $display("FAIL rnd_fwd[%0d]: got a=%h b=%h flags=%b want a=%h b=%h flags=%b", n, o_a, o_b_fwd,
          {o_forward_a, o_select_forward_a, o_forward_b, o_select_forward_b}, ea, eb, {efa, esa, efb, esb});
      end
      ncmp++;
      if (o_alu_data !== ealu) begin
        nfail++; errs++;
        if (errs < 10) $display("FAIL rnd_alu[%0d] op=%0d: got %h want %h", n, int'(i_alu_op), o_alu_data, ealu);
      end
      ncmp++;
      if (o_cmp !== ecmp) begin
        nfail++; errs++;
        if (errs < 10) $display("FAIL rnd_cmp[%0d] op=%0d: got %b want %b", n, int'(i_cmp_op), o_cmp, ecmp);
      end
      if (i_enable) begin exp_alu_q = ealu; exp_b_q = eb; end
      @(posedge clk); #1;
      ncmp++;
      if (o_alu_data_q !== exp_alu_q || o_reg_b_q !== exp_b_q) begin
        nfail++; errs++;
        if (errs < 10) $display("FAIL rnd_q[%0d]: got %h/%h want %h/%h", n, o_alu_data_q, o_reg_b_q, exp_alu_q, exp_b_q);
      end
    end
  endtask

  initial begin
    test_reset();
    test_no_hazard();
    test_m_forward();
    test_priority();
    test_offset();
    test_compare();
    test_reset_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/exe_fwd_unit.md
Name: exe_fwd_unit

Overview:
- Execute-stage datapath slice of the caballoloco pipelined core.
- Contains three functions:
  - operand forwarding resolution from the M and W stages;
  - the ALU;
  - the branch comparator.
- Registers the ALU result and the forwarded store data into the A→M pipeline boundary.
- The forwarding/compare logic also serves the decode stage for early branch resolution. Decode instantiates a second copy with the registered outputs left unused.

Parameters:
REG_WIDTH, 32, data width of operands and results
REG_SELECT, 4, register-index width (clog2 of register count)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
i_enable  in  1  pipeline-register write enable (0 = hold)
i_reg_a_select  in  REG_SELECT  source A register index
i_reg_b_select  in  REG_SELECT  source B register index
i_reg_a  in  REG_WIDTH  register-file value of A
i_reg_b  in  REG_WIDTH  register-file value of B
i_is_write_M  in  1  M-stage instruction writes a register
i_reg_c_select_M  in  REG_SELECT  M-stage destination index
i_data_M  in  REG_WIDTH  M-stage ALU result
i_is_write_W  in  1  W-stage instruction writes a register
i_reg_c_select_W  in  REG_SELECT  W-stage destination index
i_data_W  in  REG_WIDTH  W-stage writeback value
i_use_offset  in  1  ALU B operand = offset (load/store)
i_offset  in  REG_WIDTH  sign-extended immediate
i_alu_op  in  alu_op_e  ALU operation
i_cmp_op  in  cmp_op_e  comparator operation
o_forward_a / o_forward_b  out  1  operand taken from the bypass path
o_select_forward_a / o_select_forward_b  out  1  bypass source: 1 = W, 0 = M
o_a  out  REG_WIDTH  resolved operand A
o_b_fwd  out  REG_WIDTH  resolved operand B, before the offset mux
o_alu_data  out  REG_WIDTH  combinational ALU result
o_cmp  out  1  combinational compare result (branch taken)
o_alu_data_q  out  REG_WIDTH  registered ALU result
o_reg_b_q  out  REG_WIDTH  registered o_b_fwd (store data)

Behaviour:
- Forwarding, per operand X ∈ {a, b}:
  - The M stage hits when i_is_write_M is 1 and i_reg_c_select_M equals i_reg_X_select. A hit sets forward=1 and select=0 (data from i_data_M).
  - Otherwise the W stage hits when i_is_write_W is 1 and i_reg_c_select_W equals i_reg_X_select. A hit sets forward=1 and select=1 (data from i_data_W).
  - With no hit: forward=0, select=0, and the operand is taken from i_reg_X.
  - When M and W both match the same index, M wins.
  - Register 0 is an ordinary register and is forwarded like any other.
- Operand B: ALU B = i_use_offset ? i_offset : o_b_fwd.
- ALU (combinational, results modulo 2^REG_WIDTH):
  - ADD, SUB, AND, OR, XOR.
  - SLL, SRL, SRA: shift amount = low clog2(REG_WIDTH) bits of B.
  - SLT (signed) and SLTU (unsigned): result is 1 or 0, zero-extended.
  - Unknown encoding yields 0.
- Comparator (combinational), operating on o_a and o_b_fwd:
  - NONE → 0.
  - EQ, NE.
  - LT, GE (signed); LTU, GEU (unsigned).
  - Unknown encoding → 0.
  - A non-branch instruction must issue NONE, so o_cmp never redirects the PC.
- Registers:
  - Reset: rst low clears o_alu_data_q and o_reg_b_q to 0 immediately, regardless of clk.
  - Update: on the rising edge with i_enable=1, the registers load o_alu_data and o_b_fwd. With i_enable=0 they hold.
  - Latency: 1 cycle from inputs to the _q outputs. All other outputs have 0 latency.
- No internal state other than the two registers. A reset released mid-operation resumes on the next edge.

Decomposition:
- alu_pkg: alu_op_e, 4-bit encoding ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9.
- cmp_pkg: cmp_op_e, 3-bit encoding NONE=0, EQ=1, NE=2, LT=3, GE=4, LTU=5, GEU=6.
- One natural sub-module: fwd_sel. It holds the pure combinational hazard-match logic for one operand and is instantiated twice. The ALU and comparator stay inline as always_comb case statements.

Test Plan:
1. No hazard: a_sel=1, b_sel=2, i_reg_a=7, i_reg_b=5, no writes, ADD → forward=0/0, o_alu_data=12; after the edge, o_alu_data_q=12.
2. M forward: i_is_write_M=1, dest_M=1, i_data_M=3, a_sel=1, i_reg_a=99, b=2, ADD → o_forward_a=1, o_select_forward_a=0, o_a=3, o_alu_data=5.
3. M and W priority: dest_M=dest_W=2, i_data_M=10, i_data_W=20, b_sel=2 → o_b_fwd=10, o_select_forward_b=0. Then set i_is_write_M=0 → o_b_fwd=20, o_select_forward_b=1.
4. Load/store offset: i_use_offset=1, i_offset=4, o_a=1, b_fwd=9, ADD → o_alu_data=5. On the edge, o_reg_b_q=9.
5. Comparator: a=2, b=2: EQ → 1, NE → 0, NONE → 0. a=-1, b=1: LT → 1, LTU → 0.
6. Reset and hold: load o_alu_data_q=5, drive rst low between edges → outputs 0 at once. Release reset, set i_enable=0, change inputs → o_alu_data_q holds 0 across 3 edges.
